register_buffer: RTL and testbench
==================================

# register_buffer

Parametrised, flop-based elastic buffer that generalises our single-bit clocked register into a WIDTH-bit, DEPTH-entry first-in/first-out stage. It has a valid/ready handshake on both sides. It sits between producer and consumer blocks that need registered decoupling and backpressure without a RAM macro. All outputs are driven from flops, so it also breaks timing paths.

## Interface
- WIDTH, 8: data bits per entry, ≥1.
- DEPTH, 4: number of entries; power of two, ≥2.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all entries.
- in_data  input  WIDTH  write data.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  buffer accepts this cycle.
- out_data  output  WIDTH  head-of-queue data.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer takes head this cycle.
- level  output  $clog2(DEPTH)+1  occupancy, 0..DEPTH; present only with REGISTER_BUFFER_LEVEL_EN.

## Operation
- Storage: DEPTH×WIDTH flop array, circular. wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide, with the extra MSB used as the wrap bit.
- Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ.
- Push when in_valid && in_ready: write mem[wr_ptr], then wr_ptr+1.
- Pop when out_valid && out_ready: rd_ptr+1.
- Push and pop in the same cycle: both happen, occupancy is unchanged.
- in_ready = !full. out_valid = !empty. out_data = mem[rd_ptr low bits].
- Pointer arithmetic is modulo 2·DEPTH with natural wrap. No bypass path, so an empty buffer never forwards in_data in the same cycle.
- flush=1: at the next edge both pointers go to 0 and occupancy goes to 0. Storage contents are not cleared. flush overrides any push or pop in that cycle, and the flushed beat is dropped.
- Handshake rules for the producer: once in_valid is asserted it must hold it and in_data stable until accepted.
- Handshake rules for the buffer: out_valid and out_data hold stable until popped or flushed.
- Reset (rst_n=0, at any time including mid-transfer) forces:
  - pointers = 0, all mem entries = 0;
  - out_valid=0, out_data=0, in_ready=1, level=0.
  - Any partial traffic is discarded.

## Timing
- Latency: a beat accepted at edge N is visible on out_valid/out_data after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle sustained when the consumer holds out_ready=1.
- in_ready, out_valid, out_data and level are functions of flops only. There is no combinational path from in_valid, in_data or out_ready to any output.
- Full with out_ready=1: the pop happens at the edge, and in_ready rises in the next cycle. A same-cycle push into a full buffer is not accepted.
- After a flush, in_ready=1 and out_valid=0 in the following cycle.

## Configuration
- REGISTER_BUFFER_LEVEL_EN defined:
  - adds the level output, driven from a registered occupancy counter;
  - the counter does +1 on push only, −1 on pop only, and is unchanged on push+pop;
  - it is cleared by flush and by reset.
- REGISTER_BUFFER_LEVEL_EN undefined: no level port and no counter; behaviour is otherwise identical.

## Structure
- Package register_buffer_pkg holds:
  - the function computing pointer width, $clog2(DEPTH)+1;
  - the level width constant helper;
  - the default WIDTH and DEPTH constants.
- Sub-module register_bank: a DEPTH×WIDTH flop array with async active-low reset to 0, a single write port (we, waddr, wdata) and an asynchronous read port (raddr→rdata).
- The top level owns the pointers, full/empty logic, handshake and optional counter.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 and in_data=8'hAA → in_ready=1, out_valid=0, out_data=0, level=0. After release, the first push of 8'hAA gives out_data=8'hAA, out_valid=1 one edge later.
- Fill: with out_ready=0, push 8'h01..8'h04 (DEPTH=4) → in_ready=0 after the fourth push, level=4, and an attempted fifth beat 8'h05 is held off. Then with out_ready=1, the pops return 01, 02, 03, 04 in order.
- Streaming: continuous in_valid and out_ready for 20 beats (incrementing data) → one beat per cycle, output equals input delayed by 1 cycle, pointers wrap with no loss.
- Simultaneous push and pop at level=2 → level stays 2 and ordering is preserved. At full, the push is refused while the pop completes, and in_ready=1 next cycle.
- Flush with 3 entries held and a concurrent push of 8'h77 → next cycle out_valid=0, level=0, and 8'h77 never appears on the output.
- Asynchronous reset asserted mid-stream between clock edges → outputs go to their reset values immediately, without waiting for an edge.

Source files
------------

// File: rtl/register_buffer_pkg.sv
// register_buffer_pkg: shared sizing helpers and defaults
// for the register_buffer elastic stage.
package register_buffer_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/register_buffer_bank.sv
// register_bank: DEPTH x WIDTH flop array, one write port,
// asynchronous read port, async active-low clear to zero.
module register_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/register_buffer.sv
// register_buffer: flop-based valid/ready FIFO stage.
// Define REGISTER_BUFFER_LEVEL_EN to add the level output.
module register_buffer
  import register_buffer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef REGISTER_BUFFER_LEVEL_EN
  ,
  output logic [lvl_w(DEPTH)-1:0]   level
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Wrap bit distinguishes full from empty at equal low bits.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) &&
                 (wr_q[AW] != rd_q[AW]);

  assign push = in_valid && !full;
  assign pop  = out_ready && !empty;

  assign in_ready  = !full;
  assign out_valid = !empty;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  register_bank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (push && !flush),
    .waddr_i (wr_q[AW-1:0]),
    .wdata_i (in_data),
    .raddr_i (rd_q[AW-1:0]),
    .rdata_o (out_data)
  );

`ifdef REGISTER_BUFFER_LEVEL_EN
  localparam int LW = lvl_w(DEPTH);

  logic [LW-1:0] lvl_q, lvl_d;

  always_comb begin
    lvl_d = lvl_q;
    if (flush) begin
      lvl_d = '0;
    end else if (push && !pop) begin
      lvl_d = lvl_q + LW'(1);
    end else if (pop && !push) begin
      lvl_d = lvl_q - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q <= '0;
    end else begin
      lvl_q <= lvl_d;
    end
  end

  assign level = lvl_q;
`endif

endmodule

// File: tb/tb_register_buffer.sv
// tb_register_buffer: queue-model scoreboard with directed
// and randomized valid/ready traffic for register_buffer.
module tb_register_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
`ifdef REGISTER_BUFFER_LEVEL_EN
  logic [LW-1:0]    level;
`endif

  int errors = 0;
  int checks = 0;
  bit run    = 1'b0;
  bit watch77 = 1'b0;

  logic [WIDTH-1:0] exp_q [$];

  always #5 clk = ~clk;

  register_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef REGISTER_BUFFER_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: an ordered queue of accepted beats, capacity DEPTH.
  always @(posedge clk or negedge rst_n) begin
    bit pu, po;
    if (!rst_n) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else begin
      pu = in_valid && (exp_q.size() < DEPTH);
      po = out_ready && (exp_q.size() > 0);
      if (po) void'(exp_q.pop_front());
      if (pu) exp_q.push_back(in_data);
    end
  end

  // Monitor: compare the presented head and status mid-cycle.
  always @(negedge clk) begin
    if (run && rst_n) begin
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
      if (exp_q.size() != 0)
        chk("out_data", 32'(out_data), 32'(exp_q[0]));
`ifdef REGISTER_BUFFER_LEVEL_EN
      chk("level", 32'(level), 32'(exp_q.size()));
`endif
      if (watch77 && out_valid)
        chk("flushed_77_seen", 32'(out_data == 8'h77), 32'd0);
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d,
                     input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    out_ready = 1'b0;
    #23;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
`ifdef REGISTER_BUFFER_LEVEL_EN
    chk("rst_level", 32'(level), 32'd0);
`endif
    #5;
    rst_n = 1'b1;
    run   = 1'b1;
    @(posedge clk);
    #1;
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_data", 32'(out_data), 32'hAA);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Fill to capacity, then hold off a fifth beat.
    for (int i = 1; i <= DEPTH; i++)
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    cyc(1'b1, 8'h05, 1'b0, 1'b0);
    cyc(1'b1, 8'h05, 1'b0, 1'b0);
    cyc(1'b1, 8'h05, 1'b1, 1'b0);
    chk("after_pop_ready", 32'(in_ready), 32'd1);
    cyc(1'b1, 8'h05, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++)
      cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Streaming at one beat per cycle across pointer wrap.
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Concurrent push and pop at two entries.
    cyc(1'b1, 8'h31, 1'b0, 1'b0);
    cyc(1'b1, 8'h32, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with three held and a concurrent push of 77.
    cyc(1'b1, 8'h51, 1'b0, 1'b0);
    cyc(1'b1, 8'h52, 1'b0, 1'b0);
    cyc(1'b1, 8'h53, 1'b0, 1'b0);
    watch77 = 1'b1;
    cyc(1'b1, 8'h77, 1'b0, 1'b1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    watch77 = 1'b0;

    // Randomized traffic honouring the producer hold rule.
    acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (acc || flush) begin
        in_valid = 1'($urandom_range(0, 2) != 0);
        in_data  = 8'($urandom);
      end
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      acc       = in_valid && in_ready && !flush;
      @(posedge clk);
      #1;
    end

    // Asynchronous reset between edges with data in flight.
    cyc(1'b1, 8'h61, 1'b0, 1'b0);
    cyc(1'b1, 8'h62, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_data", 32'(out_data), 32'd0);
`ifdef REGISTER_BUFFER_LEVEL_EN
    chk("arst_level", 32'(level), 32'd0);
`endif
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'h99, 1'b1, 1'b0);
    chk("post_arst_data", 32'(out_data), 32'h99);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
